// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//   Two-master arbiter in front of a single-port data-memory IP (registered
//   read, write-first). Master 0 is the CPU, master 1 the DMA/debug port.
//   A request is granted and issued to memory in the same cycle; the granted
//   master sees a one-cycle rvalid pulse (reads and writes alike) in the
//   following cycle, carrying the memory read data.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   -> ties alternate using a 1-bit last-grant register
//     undefined -> m0 always wins ties (m1 may starve)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   mX_req/be/addr/wdata       requester X access (be == 0 means read)
//   mX_gnt                     request X issued this cycle
//   mX_rvalid/rdata            completion pulse and read data for X
//   mem_we/addr/din, mem_dout  data-memory port (wea/addra/dina/douta)
//   wait_cnt                   saturating count of cycles with both requests
// ---------------------------------------------------------------------------
module dm_arbiter #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [3:0]        m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [3:0]        m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [15:0]       wait_cnt
);

    logic              busy_q,  busy_d;
    logic              owner_q, owner_d;     // 1 = m1 owns the pending completion
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       din_q,   din_d;
    logic [15:0]       wait_q,  wait_d;
    logic              any_gnt;
    logic              sel_m1;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_q,  last_d;      // 1 = m1 was granted last
`endif

    // Grant selection. Nothing is granted while reset is high.
    always_comb begin
        any_gnt = 1'b0;
        sel_m1  = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                any_gnt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                sel_m1  = ~last_q;
`else
                sel_m1  = 1'b0;
`endif
            end else if (m0_req) begin
                any_gnt = 1'b1;
            end else if (m1_req) begin
                any_gnt = 1'b1;
                sel_m1  = 1'b1;
            end
        end
    end

    // Memory port drive; address and data hold their last driven value
    // when idle so the memory sees a stable bus.
    always_comb begin
        mem_we   = 4'b0000;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (any_gnt) begin
            mem_we   = sel_m1 ? m1_be    : m0_be;
            mem_addr = sel_m1 ? m1_addr  : m0_addr;
            mem_din  = sel_m1 ? m1_wdata : m0_wdata;
        end
    end

    always_comb begin
        addr_d  = mem_addr;
        din_d   = mem_din;
        busy_d  = any_gnt;
        owner_d = any_gnt ? sel_m1 : owner_q;
        wait_d  = wait_q;
        if (m0_req && m1_req && (wait_q != 16'hFFFF)) begin
            wait_d = wait_q + 16'd1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = any_gnt ? sel_m1 : last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            wait_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // A reset arriving in the completion cycle drops that completion.
    always_comb begin
        m0_gnt    = any_gnt & ~sel_m1;
        m1_gnt    = any_gnt &  sel_m1;
        m0_rvalid = busy_q & ~owner_q & ~reset;
        m1_rvalid = busy_q &  owner_q & ~reset;
        m0_rdata  = m0_rvalid ? mem_dout : 32'd0;
        m1_rdata  = m1_rvalid ? mem_dout : 32'd0;
        wait_cnt  = wait_q;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the width of the data-memory word address (addresses data-memory bits [12:2]).
REQ-002 clk  input  1  SHALL be the single clock; the data-memory IP and all state in this block SHALL be clocked by it.
REQ-003 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 m0_req  input  1  SHALL be the CPU access request; it stays high until granted.
REQ-005 m0_be  input  4  SHALL be the CPU byte enables: 0000 means read, any nonzero value means write.
REQ-006 m0_addr  input  ADDR_W  SHALL be the CPU word address.
REQ-007 m0_wdata  input  32  SHALL be the CPU write data, already lane-replicated.
REQ-008 m0_gnt  output  1  SHALL indicate the CPU request is issued this cycle.
REQ-009 m0_rvalid  output  1  SHALL be a one-cycle completion pulse.
REQ-010 m0_rdata  output  32  SHALL be the read data, valid with m0_rvalid.
REQ-011 m1_req, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata SHALL form an identical port set for the DMA/debug requester.
REQ-012 mem_we  output  4  SHALL drive the data-memory write-enable (wea).
REQ-013 mem_addr  output  ADDR_W  SHALL drive the data-memory address (addra).
REQ-014 mem_din  output  32  SHALL drive the data-memory write data (dina).
REQ-015 mem_dout  input  32  SHALL carry the data-memory read data (douta), with 1-cycle registered latency.
REQ-016 wait_cnt  output  16  SHALL count contention cycles.

Function
REQ-017 At most one of m0_gnt/m1_gnt SHALL be high per cycle; gnt is combinational from req and arbitration state, so a request is issued in the same cycle it is granted.
REQ-018 When exactly one master requests, that master SHALL be granted.
REQ-019 When both masters request, the winner SHALL be chosen per REQ-030/REQ-031.
REQ-020 The granted master's be/addr/wdata SHALL drive mem_we/mem_addr/mem_din.
REQ-021 With no grant, mem_we SHALL be 0000 and mem_addr/mem_din SHALL hold their last driven values.
REQ-022 The block SHALL register owner (1 bit) and busy (1 bit) on every grant; busy SHALL clear in any cycle with no grant.
REQ-023 In the cycle after a grant, the owner's rvalid SHALL pulse high for exactly 1 cycle, for both reads and writes.
REQ-024 The owner's rdata SHALL equal mem_dout in that cycle.
REQ-025 The non-owner's rdata SHALL be 0.
REQ-026 Back-to-back grants SHALL be allowed every cycle: grant in cycle N produces rvalid in cycle N+1, independent of the grant issued in cycle N+1.
REQ-027 wait_cnt SHALL increment by 1 in each cycle where m0_req and m1_req are both high.
REQ-028 wait_cnt SHALL saturate at 16'hFFFF with no wrap.
REQ-029 A write followed next cycle by a read to the same address SHALL return the new data (memory write-first behaviour); the block SHALL add no forwarding of its own.

Configuration
REQ-030 With macro ARB_ROUND_ROBIN_EN defined, a 1-bit last-grant register SHALL update on every grant, and on a tie the master not last granted SHALL win.
REQ-031 With ARB_ROUND_ROBIN_EN undefined, m0 SHALL always win ties (fixed priority), the last-grant register SHALL NOT exist, and m1 MAY starve.

Reset
REQ-032 While reset is high, m0_gnt, m1_gnt, m0_rvalid and m1_rvalid SHALL be 0, and mem_we SHALL be 0000 regardless of req.
REQ-033 On reset: busy=0, owner=0, wait_cnt=0, mem_addr=0, mem_din=0, last-grant=m1 (so m0 wins the first tie).
REQ-034 Reset asserted in the cycle after a grant SHALL suppress the pending rvalid; that transaction is lost and the requester SHALL re-request.

Verification
REQ-035 Reset, then m0 read addr 0x005 with memory word 0x12345678 -> m0_gnt in cycle 0, m0_rvalid and m0_rdata=0x12345678 in cycle 1, m1_rvalid=0.
REQ-036 m1 write be=1111 addr 0x010 data 0xDEADBEEF, then m1 read addr 0x010 next cycle -> two consecutive gnts, second rvalid returns 0xDEADBEEF.
REQ-037 Both masters request continuously for 4 cycles with ARB_ROUND_ROBIN_EN defined -> grant order m0,m1,m0,m1; wait_cnt=4.
REQ-038 Same stimulus as REQ-037 without ARB_ROUND_ROBIN_EN -> m0 granted all 4 cycles, m1_gnt stays 0, wait_cnt=4.
REQ-039 m0 read granted, reset asserted next cycle -> m0_rvalid=0, wait_cnt=0, mem_we=0000 during reset.
REQ-040 wait_cnt preloaded to 16'hFFFE by 3 contention cycles past it -> wait_cnt holds 16'hFFFF.
